// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pulls words from fifo_syn's registered read port and presents them as a valid/ready stream.
// Optional word counter port enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_buf [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            pending;
    logic [1:0]            occ_next;

    assign m_valid = (occ != 2'd0);
    assign m_data  = data_buf[head];
    assign pop     = m_valid && m_ready;
    assign busy    = (state != IDLE);

    // Words already buffered plus the one the FIFO is still producing; a pop this edge frees a slot.
    assign pending    = occ + {1'b0, inflight};
    assign fifo_rd_en = (state == RUN) && en && !fifo_empty &&
                        ((pending < 2'd2) || ((pending == 2'd2) && pop));

    always_comb begin
        occ_next = occ;
        if (inflight && !pop)
            occ_next = occ + 2'd1;
        else if (!inflight && pop)
            occ_next = occ - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_buf[0] <= '0;
            data_buf[1] <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) begin
                data_buf[tail] <= fifo_data_out;
                tail           <= ~tail;
            end
            if (pop)
                head <= ~head;
            occ <= occ_next;
        end
    end

    // DRAIN keeps delivering what was buffered or in flight when en dropped, then returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en)
                        state <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        if ((occ != 2'd0) || inflight)
                            state <= DRAIN;
                        else
                            state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (en)
                        state <= RUN;
                    else if (occ_next == 2'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word_cnt <= '0;
        else if (pop)
            word_cnt <= word_cnt + 1'b1;
    end
`else
    localparam bit unused_cnt_cfg = (CNT_WIDTH > 0);
`endif

endmodule
